// File: rtl/usr_seq_shift.sv
// Sequential universal shifter: loads an operand on start, then shifts one bit
// position per clock in the latched mode for amt cycles, and pulses done when finished.
module usr_seq_shift #(
  parameter int N     = 16,
  parameter int AMT_W = 4,
  parameter int SAT   = 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic             dbit,
  input  logic [N-1:0]     data_in,
  output logic [N-1:0]     data_out,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  // Handshake: start is a request taken on any rising edge while not busy
  // (IDLE or DONE); done is a one-cycle completion strobe and data_out is
  // valid from that cycle until the next accepted start.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [2:0]       mode_q;
  logic [AMT_W-1:0] cnt;
  logic [N-1:0]     shifted;
  logic [N-1:0]     sat_val;
  logic             ovf_now;

  assign dbg_state = state;
  assign ovf_now   = (mode_q == 3'd2) && (data_out[N-1] != data_out[N-2]);
  assign sat_val   = data_out[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};

  always_comb begin
    shifted = data_out;
    case (mode_q)
      3'd0: shifted = {data_out[N-2:0], 1'b0};
      3'd1: shifted = {1'b0, data_out[N-1:1]};
      3'd2: begin
        // Once saturated, the clamped value is held for the remaining cycles.
        if (SAT != 0 && ovf)          shifted = data_out;
        else if (SAT != 0 && ovf_now) shifted = sat_val;
        else                          shifted = {data_out[N-2:0], 1'b0};
      end
      3'd3: shifted = {data_out[N-1], data_out[N-1:1]};
      3'd4: shifted = {data_out[N-2:0], data_out[N-1]};
      3'd5: shifted = {data_out[0], data_out[N-1:1]};
      3'd6: shifted = {data_out[N-2:0], dbit};
      3'd7: shifted = {dbit, data_out[N-1:1]};
      default: shifted = data_out;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= IDLE;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      cnt      <= '0;
      mode_q   <= 3'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            data_out <= data_in;
            mode_q   <= mode;
            cnt      <= amt;
            ovf      <= 1'b0;
            if (amt != '0) begin
              state <= SHIFT;
              busy  <= 1'b1;
              done  <= 1'b0;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else if (state == DONE) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        SHIFT: begin
          data_out <= shifted;
          cnt      <= cnt - AMT_W'(1);
          if (ovf_now) ovf <= 1'b1;
          if (cnt == AMT_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usr_seq_shift.sv
// Bench for usr_seq_shift: saturating and wrapping instances share stimulus;
// per-instance monitors pop expected {ovf, data_out} and done cycle on each done strobe.
module tb_usr_seq_shift;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        start;
  logic [2:0]  mode;
  logic [3:0]  amt;
  logic        dbit;
  logic [15:0] data_in;

  logic [15:0] data_s, data_w;
  logic        busy_s, busy_w, done_s, done_w, ovf_s, ovf_w;
  logic [1:0]  st_s, st_w;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  logic [16:0] exp_sat_q[$];
  logic [16:0] exp_wrap_q[$];
  int          cyc_sat_q[$];
  int          cyc_wrap_q[$];
  logic [16:0] e_s, e_w;
  int          c_s, c_w;

  usr_seq_shift #(.N(16), .AMT_W(4), .SAT(1)) u_sat (
    .clk(clk), .clr_n(clr_n), .start(start), .mode(mode), .amt(amt), .dbit(dbit),
    .data_in(data_in), .data_out(data_s), .busy(busy_s), .done(done_s), .ovf(ovf_s),
    .dbg_state(st_s)
  );

  usr_seq_shift #(.N(16), .AMT_W(4), .SAT(0)) u_wrap (
    .clk(clk), .clr_n(clr_n), .start(start), .mode(mode), .amt(amt), .dbit(dbit),
    .data_in(data_in), .data_out(data_w), .busy(busy_w), .done(done_w), .ovf(ovf_w),
    .dbg_state(st_w)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitors
  always @(negedge clk) begin
    if (clr_n && done_s) begin
      if (exp_sat_q.size() == 0) check("sat unexpected done", 32'd1, 32'd0);
      else begin
        e_s = exp_sat_q.pop_front();
        c_s = cyc_sat_q.pop_front();
        check("sat result {ovf,data}", {15'd0, ovf_s, data_s}, {15'd0, e_s});
        check("sat done cycle", cyc, c_s);
      end
    end
    if (clr_n && done_w) begin
      if (exp_wrap_q.size() == 0) check("wrap unexpected done", 32'd1, 32'd0);
      else begin
        e_w = exp_wrap_q.pop_front();
        c_w = cyc_wrap_q.pop_front();
        check("wrap result {ovf,data}", {15'd0, ovf_w, data_w}, {15'd0, e_w});
        check("wrap done cycle", cyc, c_w);
      end
    end
  end

  // driver: one operation, optionally with a stray start pulse mid-shift
  task automatic run_op(input logic [2:0] m, input logic [3:0] a, input logic [15:0] d,
                        input logic [15:0] dseq, input logic [15:0] first_exp,
                        input logic [16:0] exp_s, input logic [16:0] exp_w, input bit intrude);
    int busy_cnt = 0;
    int j = 0;
    bit seen_s = 0;
    bit seen_w = 0;
    @(negedge clk);
    mode = m; amt = a; data_in = d; start = 1'b1;
    exp_sat_q.push_back(exp_s);
    exp_wrap_q.push_back(exp_w);
    cyc_sat_q.push_back(cyc + 1 + int'(a));
    cyc_wrap_q.push_back(cyc + 1 + int'(a));
    @(negedge clk);
    start = 1'b0; mode = ~m; amt = a + 4'd3; data_in = ~d;
    while (!(seen_s && seen_w) && j < 40) begin
      if (j < 16) dbit = dseq[j];
      if (intrude && j == 2) begin
        start = 1'b1; mode = 3'd1; amt = 4'd1; data_in = 16'hFFFF;
      end
      if (intrude && j == 3) start = 1'b0;
      if (busy_s) busy_cnt++;
      if (done_s) seen_s = 1'b1;
      if (done_w) seen_w = 1'b1;
      if (j == 1 && a != 4'd0) check("sat first shift", {16'd0, data_s}, {16'd0, first_exp});
      if (!(seen_s && seen_w)) begin
        @(negedge clk);
        j++;
      end
    end
    start = 1'b0;
    if (j >= 40) check("done timeout", 32'd0, 32'd1);
    check("busy cycles", busy_cnt, int'(a));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " data_s"}, {16'd0, data_s}, 32'd0);
    check({tag, " data_w"}, {16'd0, data_w}, 32'd0);
    check({tag, " busy/done/ovf"}, {26'd0, busy_s, done_s, ovf_s, busy_w, done_w, ovf_w}, 32'd0);
    check({tag, " state"}, {28'd0, st_s, st_w}, 32'd0);
  endtask

  initial begin
    clr_n = 1'b0; start = 1'b0; mode = 3'd0; amt = 4'd0; dbit = 1'b0; data_in = 16'h0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    clr_n = 1'b1;

    //      mode  amt    data_in   dseq      first     exp sat          exp wrap         intrude
    run_op(3'd1, 4'd3,  16'h8000, 16'h0000, 16'h4000, {1'b0,16'h1000}, {1'b0,16'h1000}, 1'b0);
    run_op(3'd3, 4'd4,  16'hFF00, 16'h0000, 16'hFF80, {1'b0,16'hFFF0}, {1'b0,16'hFFF0}, 1'b0);
    run_op(3'd4, 4'd1,  16'h8001, 16'h0000, 16'h0003, {1'b0,16'h0003}, {1'b0,16'h0003}, 1'b0);
    run_op(3'd2, 4'd3,  16'h3000, 16'h0000, 16'h6000, {1'b1,16'h7FFF}, {1'b1,16'h8000}, 1'b0);
    run_op(3'd0, 4'd0,  16'h1234, 16'h0000, 16'h0000, {1'b0,16'h1234}, {1'b0,16'h1234}, 1'b0);
    run_op(3'd6, 4'd4,  16'h0000, 16'h000D, 16'h0001, {1'b0,16'h000B}, {1'b0,16'h000B}, 1'b0);
    run_op(3'd0, 4'd4,  16'h00F1, 16'h0000, 16'h01E2, {1'b0,16'h0F10}, {1'b0,16'h0F10}, 1'b0);
    run_op(3'd5, 4'd2,  16'h0003, 16'h0000, 16'h8001, {1'b0,16'hC000}, {1'b0,16'hC000}, 1'b0);
    run_op(3'd7, 4'd2,  16'h8000, 16'h0002, 16'h4000, {1'b0,16'hA000}, {1'b0,16'hA000}, 1'b0);
    run_op(3'd2, 4'd2,  16'hA000, 16'h0000, 16'h8000, {1'b1,16'h8000}, {1'b1,16'h8000}, 1'b0);
    run_op(3'd2, 4'd4,  16'h0003, 16'h0000, 16'h0006, {1'b0,16'h0030}, {1'b0,16'h0030}, 1'b0);
    run_op(3'd1, 4'd15, 16'hFFFF, 16'h0000, 16'h7FFF, {1'b0,16'h0001}, {1'b0,16'h0001}, 1'b0);
    run_op(3'd0, 4'd5,  16'h0001, 16'h0000, 16'h0002, {1'b0,16'h0020}, {1'b0,16'h0020}, 1'b1);

    // abort an amt=8 shift during its second cycle
    @(negedge clk);
    mode = 3'd0; amt = 4'd8; data_in = 16'h0101; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 clr_n = 1'b0;
    #1 check_reset_state("async clear");
    repeat (3) @(negedge clk);
    check_reset_state("held clear");
    clr_n = 1'b1;
    repeat (12) @(negedge clk);
    run_op(3'd0, 4'd1, 16'h0001, 16'h0000, 16'h0002, {1'b0,16'h0002}, {1'b0,16'h0002}, 1'b0);

    repeat (3) @(negedge clk);
    check("sat queue drained", exp_sat_q.size(), 32'd0);
    check("wrap queue drained", exp_wrap_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/usr_seq_shift.md
USR_SEQ_SHIFT -- requirements
Module: usr_seq_shift

Interface
REQ-001 Parameter N, default 16, data width in bits (N >= 4).
REQ-002 Parameter AMT_W, default 4, shift-amount width; max shift per operation 2^AMT_W - 1.
REQ-003 Parameter SAT, default 1; 1 = saturate arithmetic-left overflow, 0 = wrap.
REQ-004 clk  input  1  rising-edge clock, single clock domain.
REQ-005 clr_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request; sampled in IDLE or DONE only.
REQ-007 mode  input  3  operation select, sampled with start.
REQ-008 amt  input  AMT_W  shift count, sampled with start.
REQ-009 dbit  input  1  serial fill bit for modes 6/7, sampled live each shift cycle.
REQ-010 data_in  input  N  operand, sampled with start.
REQ-011 data_out  output  N  working/result register.
REQ-012 busy  output  1  high in SHIFT state.
REQ-013 done  output  1  high for exactly one cycle in DONE state.
REQ-014 ovf  output  1  sticky overflow flag for mode 2.

Function
REQ-015 FSM states IDLE, SHIFT, DONE; all outputs registered.
REQ-016 IDLE/DONE with start=1: data_out<=data_in, mode/amt latched, ovf<=0; next state SHIFT if amt>0, else DONE.
REQ-017 IDLE with start=0: hold all registers; DONE with start=0: go IDLE, data_out held.
REQ-018 SHIFT: one bit position per clock; internal counter loaded with amt, decrements each shift; leave SHIFT for DONE on the edge performing the final shift.
REQ-019 Latency: start accepted on edge k -> done high in cycle after edge k+amt (amt=0: cycle after edge k).
REQ-020 start asserted in SHIFT is ignored; latched mode/amt unaffected.
REQ-021 Mode 0: logical left, LSB<=0.
REQ-022 Mode 1: logical right, MSB<=0.
REQ-023 Mode 2: arithmetic left, LSB<=0; overflow when data_out[N-1] != data_out[N-2] before the shift.
REQ-024 Mode 3: arithmetic right, MSB replicated.
REQ-025 Mode 4: rotate left, old MSB -> LSB.
REQ-026 Mode 5: rotate right, old LSB -> MSB.
REQ-027 Mode 6: left shift, LSB<=dbit.
REQ-028 Mode 7: right shift, MSB<=dbit.
REQ-029 Mode 2 overflow: ovf<=1; SAT=1: data_out<=0x7FF..F if operand sign was 0, 0x800..0 if 1, and remaining shift cycles hold that value; SAT=0: shift proceeds normally.
REQ-030 ovf stays 0 in all modes other than 2; cleared only by an accepted start or reset.
REQ-031 data_out holds result from DONE until next accepted start.

Reset
REQ-032 clr_n=0 forces immediately, regardless of clk: state IDLE, data_out=0, busy=0, done=0, ovf=0, counter=0, latched mode/amt=0.
REQ-033 Reset asserted mid-SHIFT aborts the operation; no done pulse is produced for it.
REQ-034 After clr_n rises, the first rising clk edge with start=1 is accepted normally.

Verification
REQ-035 N=16: mode 1, data_in 0x8000, amt 3 -> busy 3 cycles, done after edge k+3, data_out 0x1000, ovf 0.
REQ-036 Mode 3, data_in 0xFF00, amt 4 -> data_out 0xFFF0; mode 4, data_in 0x8001, amt 1 -> 0x0003.
REQ-037 SAT=1, mode 2, data_in 0x3000, amt 3 -> 0x6000 after first shift, then 0x7FFF, ovf=1, held through done; SAT=0 same stimulus -> 0x8000, ovf=1.
REQ-038 amt 0, data_in 0x1234 -> done in cycle after start, busy never high, data_out 0x1234; start pulsed during a running amt=5 shift -> ignored, single done.
REQ-039 Mode 6, data_in 0x0000, amt 4, dbit sequence 1,0,1,1 -> data_out 0x000B.
REQ-040 clr_n low during cycle 2 of an amt=8 shift -> data_out 0, busy 0 without clock edge; no done; next start operates normally.
